// File: rtl/fcl_controller_if.sv
// rtl/fcl_controller_if.sv - load-config type package and controller bus interface
//
// Purpose: defines the load_cfg_req_t encoding (package defs) and groups the
//          command, engine-handshake and loader signals of fcl_controller.
// Signals:
//   i_cmd_load_cfg_1   request load of config 1 (level)
//   i_cmd_load_cfg_2   request load of config 2 (level)
//   i_FCL_allowed      engine at a safe point, a load may start
//   i_is_loading       loader busy flag
//   o_go               start-load strobe to the loader
//   o_cur_load_cfg_req config being requested/loaded, NO_REQ if none
// Modports: master drives the inputs and observes the outputs (front end /
//           loader side); slave is the controller itself.

package defs;
   typedef enum logic [1:0] {
      NO_REQ = 2'd0,
      CFG_1  = 2'd1,
      CFG_2  = 2'd2
   } load_cfg_req_t;
endpackage

interface fcl_controller_if;
   import defs::*;

   logic          i_cmd_load_cfg_1;
   logic          i_cmd_load_cfg_2;
   logic          i_FCL_allowed;
   logic          i_is_loading;
   logic          o_go;
   load_cfg_req_t o_cur_load_cfg_req;

   modport master (
      output i_cmd_load_cfg_1,
      output i_cmd_load_cfg_2,
      output i_FCL_allowed,
      output i_is_loading,
      input  o_go,
      input  o_cur_load_cfg_req
   );

   modport slave (
      input  i_cmd_load_cfg_1,
      input  i_cmd_load_cfg_2,
      input  i_FCL_allowed,
      input  i_is_loading,
      output o_go,
      output o_cur_load_cfg_req
   );
endinterface

// File: rtl/fcl_controller.sv
// rtl/fcl_controller.sv - arbitrates load-config button commands into one FCL request
//
// Purpose: rising-edge detects the two load-config commands, latches the requested
//          config, waits for the engine to allow a load, issues a single-cycle o_go,
//          then follows the loader busy flag back to idle.
// Ports:
//   clk    system clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    fcl_controller_if.slave: command inputs, FCL handshake, o_go strobe and
//          registered o_cur_load_cfg_req

module fcl_controller
   import defs::*;
(
   input logic               clk,
   input logic               rst_n,
   fcl_controller_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_STARTED,
      S_LOADING
   } state_t;

   state_t        state_q, state_d;
   load_cfg_req_t req_q, req_d;
   logic          cmd1_prev_q, cmd1_prev_d;
   logic          cmd2_prev_q, cmd2_prev_d;

   logic          cmd1_edge;
   logic          cmd2_edge;
   logic          go;

   assign cmd1_edge = bus.i_cmd_load_cfg_1 & ~cmd1_prev_q;
   assign cmd2_edge = bus.i_cmd_load_cfg_2 & ~cmd2_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         req_q       <= NO_REQ;
         cmd1_prev_q <= 1'b0;
         cmd2_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         cmd1_prev_q <= cmd1_prev_d;
         cmd2_prev_q <= cmd2_prev_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      go          = 1'b0;
      // Edge history tracks the buttons in every state, so a command that was
      // pressed (and ignored) while busy cannot fire later when we return to idle.
      cmd1_prev_d = bus.i_cmd_load_cfg_1;
      cmd2_prev_d = bus.i_cmd_load_cfg_2;

      case (state_q)
         S_IDLE: begin
            req_d = NO_REQ;
            if (cmd1_edge) begin
               state_d = S_REQ;
               req_d   = CFG_1;
            end else if (cmd2_edge) begin
               state_d = S_REQ;
               req_d   = CFG_2;
            end
         end
         S_REQ: begin
            // The accepting edge leaves REQ, so o_go is high for exactly one edge.
            go = bus.i_FCL_allowed;
            if (bus.i_FCL_allowed) begin
               state_d = bus.i_is_loading ? S_LOADING : S_STARTED;
            end
         end
         S_STARTED: begin
            if (bus.i_is_loading) begin
               state_d = S_LOADING;
            end
         end
         S_LOADING: begin
            if (!bus.i_is_loading) begin
               state_d = S_IDLE;
               req_d   = NO_REQ;
            end
         end
         default: begin
            state_d = S_IDLE;
            req_d   = NO_REQ;
         end
      endcase
   end

   assign bus.o_go               = go;
   assign bus.o_cur_load_cfg_req = req_q;

endmodule

// File: tb/tb_fcl_controller.sv
// tb/tb_fcl_controller.sv - self-checking bench for fcl_controller

module tb_fcl_controller;
   import defs::*;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   fcl_controller_if bus ();

   fcl_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: a request is either absent or active; an active request
   // has (a) not yet been granted, (b) been granted but the loader not yet seen
   // busy, or (c) the loader seen busy and we wait for it to go idle.
   load_cfg_req_t m_active;
   bit            m_granted;
   bit            m_busy_seen;
   bit            m_p1, m_p2;

   task automatic model_reset();
      m_active    = NO_REQ;
      m_granted   = 1'b0;
      m_busy_seen = 1'b0;
      m_p1        = 1'b0;
      m_p2        = 1'b0;
   endtask

   task automatic model_edge();
      bit r1, r2;
      r1 = bus.i_cmd_load_cfg_1 && !m_p1;
      r2 = bus.i_cmd_load_cfg_2 && !m_p2;
      if (m_active == NO_REQ) begin
         if (r1 || r2) begin
            m_active    = r1 ? CFG_1 : CFG_2;
            m_granted   = 1'b0;
            m_busy_seen = 1'b0;
         end
      end else if (!m_granted) begin
         if (bus.i_FCL_allowed) begin
            m_granted   = 1'b1;
            m_busy_seen = bus.i_is_loading;
         end
      end else if (!m_busy_seen) begin
         if (bus.i_is_loading) m_busy_seen = 1'b1;
      end else if (!bus.i_is_loading) begin
         m_active = NO_REQ;
      end
      m_p1 = bus.i_cmd_load_cfg_1;
      m_p2 = bus.i_cmd_load_cfg_2;
   endtask

   function automatic logic model_go();
      return (m_active != NO_REQ) && !m_granted && bus.i_FCL_allowed;
   endfunction

   // One clock: model advances on the same edge as the DUT; returns at negedge.
   task automatic cycle(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
      end
   endtask

   task automatic set_in(input logic c1, input logic c2, input logic al, input logic ld);
      bus.i_cmd_load_cfg_1 = c1;
      bus.i_cmd_load_cfg_2 = c2;
      bus.i_FCL_allowed    = al;
      bus.i_is_loading     = ld;
   endtask

   task automatic test_reset();
      set_in(0, 0, 0, 0);
      rst_n = 1'b0;
      model_reset();
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (bus.o_cur_load_cfg_req !== NO_REQ) begin
         n_fail++;
         $display("FAIL reset_req: got %0d want %0d", bus.o_cur_load_cfg_req, NO_REQ);
      end
      n_cmp++;
      if (bus.o_go !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_go: got %b want 0", bus.o_go);
      end
      // Allowed while idle must not strobe.
      bus.i_FCL_allowed = 1'b1;
      #1;
      n_cmp++;
      if (bus.o_go !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_allowed_go: got %b want 0", bus.o_go);
      end
      bus.i_FCL_allowed = 1'b0;
      cycle();
   endtask

   task automatic test_cfg1_flow();
      set_in(1, 0, 0, 0);
      cycle(3);
      #1;
      n_cmp++;
      if (bus.o_cur_load_cfg_req !== CFG_1) begin
         n_fail++;
         $display("FAIL cfg1_req_latched: got %0d want %0d", bus.o_cur_load_cfg_req, CFG_1);
      end
      n_cmp++;
      if (bus.o_go !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg1_go_not_allowed: got %b want 0", bus.o_go);
      end
      bus.i_FCL_allowed = 1'b1;
      #1;
      n_cmp++;
      if (bus.o_go !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg1_go_same_cycle: got %b want 1", bus.o_go);
      end
      bus.i_is_loading = 1'b1;
      cycle();
      #1;
      n_cmp++;
      if (bus.o_go !== 1'b0 || bus.o_cur_load_cfg_req !== CFG_1) begin
         n_fail++;
         $display("FAIL cfg1_loading: go %b req %0d want go 0 req %0d", bus.o_go, bus.o_cur_load_cfg_req, CFG_1);
      end
      bus.i_cmd_load_cfg_1 = 1'b0;
      cycle();
      #1;
      n_cmp++;
      if (bus.o_cur_load_cfg_req !== CFG_1) begin
         n_fail++;
         $display("FAIL cfg1_hold_busy: got %0d want %0d", bus.o_cur_load_cfg_req, CFG_1);
      end
      set_in(0, 0, 0, 0);
      cycle();
      #1;
      n_cmp++;
      if (bus.o_cur_load_cfg_req !== NO_REQ) begin
         n_fail++;
         $display("FAIL cfg1_done: got %0d want %0d", bus.o_cur_load_cfg_req, NO_REQ);
      end
   endtask

   task automatic test_cfg2_late_busy();
      set_in(0, 1, 0, 0);
      cycle();
      bus.i_cmd_load_cfg_2 = 1'b0;
      #1;
      n_cmp++;
      if (bus.o_cur_load_cfg_req !== CFG_2 || bus.o_go !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg2_req: req %0d go %b want req %0d go 0", bus.o_cur_load_cfg_req, bus.o_go, CFG_2);
      end
      bus.i_FCL_allowed = 1'b1;
      #1;
      n_cmp++;
      if (bus.o_go !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg2_go: got %b want 1", bus.o_go);
      end
      cycle();
      #1;
      n_cmp++;
      if (bus.o_go !== 1'b0 || bus.o_cur_load_cfg_req !== CFG_2) begin
         n_fail++;
         $display("FAIL cfg2_started: go %b req %0d want go 0 req %0d", bus.o_go, bus.o_cur_load_cfg_req, CFG_2);
      end
      bus.i_FCL_allowed = 1'b0;
      cycle(2);
      #1;
      n_cmp++;
      if (bus.o_cur_load_cfg_req !== CFG_2) begin
         n_fail++;
         $display("FAIL cfg2_wait_busy: got %0d want %0d", bus.o_cur_load_cfg_req, CFG_2);
      end
      bus.i_is_loading = 1'b1;
      cycle();
      #1;
      n_cmp++;
      if (bus.o_cur_load_cfg_req !== CFG_2) begin
         n_fail++;
         $display("FAIL cfg2_busy: got %0d want %0d", bus.o_cur_load_cfg_req, CFG_2);
      end
      bus.i_is_loading = 1'b0;
      cycle();
      #1;
      n_cmp++;
      if (bus.o_cur_load_cfg_req !== NO_REQ) begin
         n_fail++;
         $display("FAIL cfg2_done: got %0d want %0d", bus.o_cur_load_cfg_req, NO_REQ);
      end
   endtask

   task automatic test_priority_ignore();
      set_in(1, 1, 0, 0);
      cycle();
      #1;
      n_cmp++;
      if (bus.o_cur_load_cfg_req !== CFG_1) begin
         n_fail++;
         $display("FAIL prio_cfg1: got %0d want %0d", bus.o_cur_load_cfg_req, CFG_1);
      end
      set_in(1, 1, 1, 1);
      cycle();
      set_in(0, 0, 0, 1);
      cycle();
      bus.i_cmd_load_cfg_2 = 1'b1;
      cycle();
      #1;
      n_cmp++;
      if (bus.o_cur_load_cfg_req !== CFG_1) begin
         n_fail++;
         $display("FAIL ignore_in_loading: got %0d want %0d", bus.o_cur_load_cfg_req, CFG_1);
      end
      bus.i_is_loading = 1'b0;
      cycle();
      #1;
      n_cmp++;
      if (bus.o_cur_load_cfg_req !== NO_REQ) begin
         n_fail++;
         $display("FAIL ignore_done: got %0d want %0d", bus.o_cur_load_cfg_req, NO_REQ);
      end
      cycle(2);
      #1;
      n_cmp++;
      if (bus.o_cur_load_cfg_req !== NO_REQ) begin
         n_fail++;
         $display("FAIL held_no_retrigger: got %0d want %0d", bus.o_cur_load_cfg_req, NO_REQ);
      end
      set_in(0, 0, 0, 0);
      cycle();
   endtask

   task automatic test_reset_mid();
      set_in(1, 0, 0, 0);
      cycle();
      set_in(0, 0, 1, 0);
      #1;
      n_cmp++;
      if (bus.o_go !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_go_before: got %b want 1", bus.o_go);
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (bus.o_go !== 1'b0 || bus.o_cur_load_cfg_req !== NO_REQ) begin
         n_fail++;
         $display("FAIL rstmid_async: go %b req %0d want go 0 req %0d", bus.o_go, bus.o_cur_load_cfg_req, NO_REQ);
      end
      bus.i_FCL_allowed = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
   endtask

   task automatic test_random();
      logic c1, c2, al, ld;
      c1 = 0; c2 = 0; al = 0; ld = 0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 5) == 0) c1 = ~c1;
         if ($urandom_range(0, 5) == 0) c2 = ~c2;
         al = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0) ld = ~ld;
         set_in(c1, c2, al, ld);
         #1;
         n_cmp++;
         if (bus.o_go !== model_go()) begin
            n_fail++;
            $display("FAIL rand_go @%0d: got %b want %b", i, bus.o_go, model_go());
         end
         n_cmp++;
         if (bus.o_cur_load_cfg_req !== m_active) begin
            n_fail++;
            $display("FAIL rand_req @%0d: got %0d want %0d", i, bus.o_cur_load_cfg_req, m_active);
         end
         cycle();
      end
      set_in(0, 0, 0, 0);
      cycle();
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(0, 0, 0, 0);
      model_reset();
      test_reset();
      test_cfg1_flow();
      test_cfg2_late_busy();
      test_priority_ignore();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
